alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_pkg.sv | 74 +++++++
 rtl/alu_ctl_rom.sv | 21 ++
 rtl/alu_seq.sv | 201 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the sequenced ALU controller: ALU-side control enums,
// op_sel encoding, FSM states and the per-operation control tuple table.
package alu_pkg;

   typedef enum logic { NO_LD = 1'b0, BUS_LD = 1'b1 } ld_e;

   typedef enum logic [1:0] {
      NO_SH    = 2'd0,
      SH_LEFT  = 2'd1,
      SH_RIGHT = 2'd2
   } sh_e;

   typedef enum logic [1:0] {
      NO_OE  = 2'd0,
      SH_OE  = 2'd1,
      RES_OE = 2'd2
   } oe_e;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_ADC = 3'd1,
      OP_SUB = 3'd2,
      OP_SBC = 3'd3,
      OP_AND = 3'd4,
      OP_XOR = 3'd5,
      OP_OR  = 3'd6,
      OP_CP  = 3'd7
   } op_e;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LDA  = 3'd1,
      LO   = 3'd2,
      HI   = 3'd3,
      FIN  = 3'd4
   } state_e;

   // r selects the adder, s/v pick the logic function, ne inverts B, ci is carry-in
   typedef struct packed {
      logic r;
      logic s;
      logic v;
      logic ne;
      logic ci;
   } ctl_t;

   // Per-operation control tuple; ADC/SBC carry-in is patched from the carry flag later
   function automatic ctl_t op_ctl(input op_e op);
      ctl_t t;
      case (op)
         OP_ADD:  t = '{r: 1'b1, s: 1'b0, v: 1'b0, ne: 1'b0, ci: 1'b0};
         OP_ADC:  t = '{r: 1'b1, s: 1'b0, v: 1'b0, ne: 1'b0, ci: 1'b0};
         OP_SUB:  t = '{r: 1'b1, s: 1'b0, v: 1'b0, ne: 1'b1, ci: 1'b1};
         OP_SBC:  t = '{r: 1'b1, s: 1'b0, v: 1'b0, ne: 1'b1, ci: 1'b1};
         OP_AND:  t = '{r: 1'b0, s: 1'b1, v: 1'b0, ne: 1'b0, ci: 1'b1};
         OP_XOR:  t = '{r: 1'b0, s: 1'b0, v: 1'b1, ne: 1'b0, ci: 1'b0};
         OP_OR:   t = '{r: 1'b0, s: 1'b1, v: 1'b1, ne: 1'b0, ci: 1'b0};
         OP_CP:   t = '{r: 1'b1, s: 1'b0, v: 1'b0, ne: 1'b1, ci: 1'b1};
         default: t = '{r: 1'b0, s: 1'b0, v: 1'b0, ne: 1'b0, ci: 1'b0};
      endcase
      return t;
   endfunction

   // Operations whose H/C flags come from the adder carries
   function automatic logic is_arith(input op_e op);
      return (op != OP_AND) && (op != OP_XOR) && (op != OP_OR);
   endfunction

   // Operations that report a subtraction through flag_n
   function automatic logic sets_n(input op_e op);
      return (op == OP_SUB) || (op == OP_SBC) || (op == OP_CP);
   endfunction

endpackage

// File: rtl/alu_ctl_rom.sv
// Combinational lookup from the latched operation to the ALU control tuple,
// folding the carry flag into the ADC/SBC carry-in.
module alu_ctl_rom
   import alu_pkg::*;
(
   input  op_e   op,
   input  logic  cin,
   output ctl_t  ctl
);

   // Table lookup, then borrow-aware carry-in for the carry-chained ops
   always_comb begin
      ctl = op_ctl(op);
      if (op == OP_ADC) begin
         ctl.ci = cin;
      end else if (op == OP_SBC) begin
         ctl.ci = !cin;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Sequencer that drives a nibble-serial external ALU: load A, run the low
// nibble while loading B, run the high nibble, then publish result and flags.
module alu_seq
   import alu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op_sel,
   input  logic [7:0]  opa,
   input  logic [7:0]  opb,
   input  logic        flag_cin,
   output logic        busy,
   output logic        done,
   output logic [7:0]  result,
   output logic        flag_z,
   output logic        flag_n,
   output logic        flag_h,
   output logic        flag_c,
   output logic [7:0]  alu_op,
   output ld_e         alu_la,
   output ld_e         alu_lb,
   output sh_e         alu_sh,
   output oe_e         alu_oe,
   output logic        alu_r,
   output logic        alu_s,
   output logic        alu_v,
   output logic        alu_ne,
   output logic        alu_ci,
   output logic        alu_l,
   output logic        alu_h,
   input  logic [7:0]  alu_result,
   input  logic        alu_zero,
   input  logic        alu_carry
);

   state_e      state_q, state_d;
   op_e         op_q, op_d;
   logic [7:0]  b_q, b_d;
   logic        cin_q, cin_d;
   logic        half_carry_q, half_carry_d;
   logic        busy_q, busy_d, done_q, done_d;
   logic [7:0]  result_q, result_d;
   logic        flag_z_q, flag_z_d, flag_n_q, flag_n_d;
   logic        flag_h_q, flag_h_d, flag_c_q, flag_c_d;
   logic [7:0]  alu_op_q, alu_op_d;
   ld_e         alu_la_q, alu_la_d, alu_lb_q, alu_lb_d;
   sh_e         alu_sh_q, alu_sh_d;
   oe_e         alu_oe_q, alu_oe_d;
   logic [4:0]  tuple_q, tuple_d;
   logic        alu_l_q, alu_l_d, alu_h_q, alu_h_d;
   ctl_t        ctl;

   alu_ctl_rom u_rom (
      .op  (op_q),
      .cin (cin_q),
      .ctl (ctl)
   );

   // Next state plus the registered outputs for the state being entered
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      b_d          = b_q;
      cin_d        = cin_q;
      half_carry_d = half_carry_q;
      result_d     = result_q;
      flag_z_d     = flag_z_q;
      flag_n_d     = flag_n_q;
      flag_h_d     = flag_h_q;
      flag_c_d     = flag_c_q;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      alu_op_d     = 8'h00;
      alu_la_d     = NO_LD;
      alu_lb_d     = NO_LD;
      alu_sh_d     = NO_SH;
      alu_oe_d     = NO_OE;
      tuple_d      = 5'b00000;
      alu_l_d      = 1'b0;
      alu_h_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = LDA;
               op_d     = op_e'(op_sel);
               b_d      = opb;
               cin_d    = flag_cin;
               busy_d   = 1'b1;
               alu_op_d = opa;
               alu_la_d = BUS_LD;
               alu_oe_d = SH_OE;
            end
         end
         LDA: begin
            state_d  = LO;
            busy_d   = 1'b1;
            alu_op_d = b_q;
            alu_lb_d = BUS_LD;
            alu_oe_d = SH_OE;
            alu_l_d  = 1'b1;
            tuple_d  = ctl;
         end
         LO: begin
            state_d      = HI;
            half_carry_d = alu_carry;
            busy_d       = 1'b1;
            alu_oe_d     = RES_OE;
            alu_h_d      = 1'b1;
            tuple_d      = ctl;
         end
         HI: begin
            state_d = FIN;
            busy_d  = 1'b1;
            done_d  = 1'b1;
            if (op_q != OP_CP) begin
               result_d = alu_result;
            end
            flag_z_d = alu_zero;
            flag_n_d = sets_n(op_q);
            if (is_arith(op_q)) begin
               flag_h_d = half_carry_q ^ ctl.ne;
               flag_c_d = alu_carry ^ ctl.ne;
            end else begin
               flag_h_d = (op_q == OP_AND);
               flag_c_d = 1'b0;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any operation in flight
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         op_q         <= OP_ADD;
         b_q          <= 8'h00;
         cin_q        <= 1'b0;
         half_carry_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         result_q     <= 8'h00;
         flag_z_q     <= 1'b0;
         flag_n_q     <= 1'b0;
         flag_h_q     <= 1'b0;
         flag_c_q     <= 1'b0;
         alu_op_q     <= 8'h00;
         alu_la_q     <= NO_LD;
         alu_lb_q     <= NO_LD;
         alu_sh_q     <= NO_SH;
         alu_oe_q     <= NO_OE;
         tuple_q      <= 5'b00000;
         alu_l_q      <= 1'b0;
         alu_h_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         b_q          <= b_d;
         cin_q        <= cin_d;
         half_carry_q <= half_carry_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         result_q     <= result_d;
         flag_z_q     <= flag_z_d;
         flag_n_q     <= flag_n_d;
         flag_h_q     <= flag_h_d;
         flag_c_q     <= flag_c_d;
         alu_op_q     <= alu_op_d;
         alu_la_q     <= alu_la_d;
         alu_lb_q     <= alu_lb_d;
         alu_sh_q     <= alu_sh_d;
         alu_oe_q     <= alu_oe_d;
         tuple_q      <= tuple_d;
         alu_l_q      <= alu_l_d;
         alu_h_q      <= alu_h_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   assign flag_z = flag_z_q;
   assign flag_n = flag_n_q;
   assign flag_h = flag_h_q;
   assign flag_c = flag_c_q;
   assign alu_op = alu_op_q;
   assign alu_la = alu_la_q;
   assign alu_lb = alu_lb_q;
   assign alu_sh = alu_sh_q;
   assign alu_oe = alu_oe_q;
   assign {alu_r, alu_s, alu_v, alu_ne, alu_ci} = tuple_q;
   assign alu_l  = alu_l_q;
   assign alu_h  = alu_h_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural nibble-serial ALU attached.
module tb_alu_seq;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  op_sel;
   logic [7:0]  opa, opb;
   logic        flag_cin;
   logic        busy, done;
   logic [7:0]  result;
   logic        flag_z, flag_n, flag_h, flag_c;
   logic [7:0]  alu_op;
   ld_e         alu_la, alu_lb;
   sh_e         alu_sh;
   oe_e         alu_oe;
   logic        alu_r, alu_s, alu_v, alu_ne, alu_ci, alu_l, alu_h;
   logic [7:0]  alu_result;
   logic        alu_zero, alu_carry;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   alu_seq dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .op_sel     (op_sel),
      .opa        (opa),
      .opb        (opb),
      .flag_cin   (flag_cin),
      .busy       (busy),
      .done       (done),
      .result     (result),
      .flag_z     (flag_z),
      .flag_n     (flag_n),
      .flag_h     (flag_h),
      .flag_c     (flag_c),
      .alu_op     (alu_op),
      .alu_la     (alu_la),
      .alu_lb     (alu_lb),
      .alu_sh     (alu_sh),
      .alu_oe     (alu_oe),
      .alu_r      (alu_r),
      .alu_s      (alu_s),
      .alu_v      (alu_v),
      .alu_ne     (alu_ne),
      .alu_ci     (alu_ci),
      .alu_l      (alu_l),
      .alu_h      (alu_h),
      .alu_result (alu_result),
      .alu_zero   (alu_zero),
      .alu_carry  (alu_carry)
   );

   // Behavioural ALU: A/B registers, low nibble kept with its carry for the high pass
   logic [7:0] ma_q = 8'h00, mb_q = 8'h00;
   logic [3:0] mlo_q = 4'h0;
   logic       mlc_q = 1'b0;
   logic [7:0] mb_bus, mb_x;
   logic [4:0] nib_out;

   function automatic logic [4:0] nib(input logic [3:0] a, input logic [3:0] b,
                                      input logic cin, input logic r, input logic s,
                                      input logic v);
      if (r) return {1'b0, a} + {1'b0, b} + {4'b0000, cin};
      if (s && !v) return {1'b0, a & b};
      if (!s && v) return {1'b0, a ^ b};
      if (s && v) return {1'b0, a | b};
      return 5'd0;
   endfunction

   // Nibble datapath outputs as seen by the sequencer in the current cycle
   always_comb begin
      mb_bus  = (alu_lb == BUS_LD) ? alu_op : mb_q;
      mb_x    = alu_ne ? ~mb_bus : mb_bus;
      nib_out = 5'd0;
      if (alu_l) nib_out = nib(ma_q[3:0], mb_x[3:0], alu_ci, alu_r, alu_s, alu_v);
      else if (alu_h) nib_out = nib(ma_q[7:4], mb_x[7:4], mlc_q, alu_r, alu_s, alu_v);
      alu_result = {nib_out[3:0], mlo_q};
      alu_carry  = nib_out[4];
      alu_zero   = (alu_result == 8'h00);
   end

   // ALU register loads and low-nibble capture
   always @(posedge clk) begin
      if (alu_la == BUS_LD) ma_q <= alu_op;
      if (alu_lb == BUS_LD) mb_q <= alu_op;
      if (alu_l) begin
         mlo_q <= nib_out[3:0];
         mlc_q <= nib_out[4];
      end
   end

   // Issue one operation and watch 10 cycles after acceptance (sampled on negedges)
   task automatic applyStimulus(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                input logic cin, input int pulse_at, output int lat,
                                output int n_done, output int n_busy, output logic [9:0] lb_mask);
      @(negedge clk);
      op_sel = op; opa = a; opb = b; flag_cin = cin; start = 1'b1;
      @(posedge clk);
      lat = -1; n_done = 0; n_busy = 0; lb_mask = '0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (done) begin
            n_done++;
            if (lat < 0) lat = i;
         end
         if (busy) n_busy++;
         if (alu_lb == BUS_LD) lb_mask[i-1] = 1'b1;
         start = (i == pulse_at);
         if (i == pulse_at) begin
            op_sel = 3'd5; opa = 8'h00; opb = 8'h00;
         end
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      tests++;
      if ({result, flag_z, flag_n, flag_h, flag_c} !== 12'h000) begin
         fails++; $display("[TB] FAIL reset_outcome: got %h want 000", {result, flag_z, flag_n, flag_h, flag_c});
      end
      tests++;
      if ({busy, done} !== 2'b00) begin
         fails++; $display("[TB] FAIL reset_busy_done: got %b want 00", {busy, done});
      end
      tests++;
      if (alu_oe !== NO_OE || alu_la !== NO_LD || alu_lb !== NO_LD || alu_sh !== NO_SH) begin
         fails++; $display("[TB] FAIL reset_alu_enums: got oe=%0d la=%0d lb=%0d sh=%0d want 0", alu_oe, alu_la, alu_lb, alu_sh);
      end
      tests++;
      if ({alu_op, alu_r, alu_s, alu_v, alu_ne, alu_ci, alu_l, alu_h} !== 15'h0) begin
         fails++; $display("[TB] FAIL reset_alu_bits: got %h want 0", {alu_op, alu_r, alu_s, alu_v, alu_ne, alu_ci, alu_l, alu_h});
      end
      reset = 1'b0;
   endtask

   task automatic test_and();
      int lat, nd, nb; logic [9:0] lbm;
      applyStimulus(3'd4, 8'hF0, 8'h3C, 1'b0, 0, lat, nd, nb, lbm);
      tests++;
      if (lat !== 4) begin fails++; $display("[TB] FAIL and_latency: got %0d want 4", lat); end
      tests++;
      if (nd !== 1) begin fails++; $display("[TB] FAIL and_done_count: got %0d want 1", nd); end
      tests++;
      if (lbm !== 10'b00_0000_0010) begin fails++; $display("[TB] FAIL and_lb_only_in_lo: got %b want 0000000010", lbm); end
      tests++;
      if ({result, flag_z, flag_n, flag_h, flag_c} !== {8'h30, 4'b0010}) begin
         fails++; $display("[TB] FAIL and_f0_3c: got %h want 302", {result, flag_z, flag_n, flag_h, flag_c});
      end
      tests++;
      if (alu_oe !== NO_OE || alu_op !== 8'h00) begin
         fails++; $display("[TB] FAIL idle_alu_controls: got oe=%0d op=%h want 0/00", alu_oe, alu_op);
      end
      applyStimulus(3'd4, 8'h0F, 8'hF0, 1'b0, 0, lat, nd, nb, lbm);
      tests++;
      if ({result, flag_z, flag_n, flag_h, flag_c} !== {8'h00, 4'b1010}) begin
         fails++; $display("[TB] FAIL and_0f_f0: got %h want 00a", {result, flag_z, flag_n, flag_h, flag_c});
      end
   endtask

   task automatic test_add();
      int lat, nd, nb; logic [9:0] lbm;
      applyStimulus(3'd0, 8'h0F, 8'h01, 1'b0, 0, lat, nd, nb, lbm);
      tests++;
      if ({result, flag_z, flag_n, flag_h, flag_c} !== {8'h10, 4'b0010}) begin
         fails++; $display("[TB] FAIL add_0f_01: got %h want 102", {result, flag_z, flag_n, flag_h, flag_c});
      end
      applyStimulus(3'd0, 8'h80, 8'h80, 1'b1, 0, lat, nd, nb, lbm);
      tests++;
      if ({result, flag_z, flag_n, flag_h, flag_c} !== {8'h00, 4'b1001}) begin
         fails++; $display("[TB] FAIL add_80_80: got %h want 009", {result, flag_z, flag_n, flag_h, flag_c});
      end
      applyStimulus(3'd1, 8'hFF, 8'h00, 1'b1, 0, lat, nd, nb, lbm);
      tests++;
      if ({result, flag_z, flag_n, flag_h, flag_c} !== {8'h00, 4'b1011}) begin
         fails++; $display("[TB] FAIL adc_ff_00_c1: got %h want 00b", {result, flag_z, flag_n, flag_h, flag_c});
      end
   endtask

   task automatic test_sub();
      int lat, nd, nb; logic [9:0] lbm;
      applyStimulus(3'd2, 8'h10, 8'h01, 1'b0, 0, lat, nd, nb, lbm);
      tests++;
      if ({result, flag_z, flag_n, flag_h, flag_c} !== {8'h0F, 4'b0110}) begin
         fails++; $display("[TB] FAIL sub_10_01: got %h want 0f6", {result, flag_z, flag_n, flag_h, flag_c});
      end
      applyStimulus(3'd3, 8'h10, 8'h01, 1'b1, 0, lat, nd, nb, lbm);
      tests++;
      if ({result, flag_z, flag_n, flag_h, flag_c} !== {8'h0E, 4'b0110}) begin
         fails++; $display("[TB] FAIL sbc_10_01_c1: got %h want 0e6", {result, flag_z, flag_n, flag_h, flag_c});
      end
   endtask

   task automatic test_cp();
      int lat, nd, nb; logic [9:0] lbm;
      applyStimulus(3'd5, 8'hAA, 8'hFF, 1'b0, 0, lat, nd, nb, lbm);
      tests++;
      if ({result, flag_z, flag_n, flag_h, flag_c} !== {8'h55, 4'b0000}) begin
         fails++; $display("[TB] FAIL xor_aa_ff: got %h want 550", {result, flag_z, flag_n, flag_h, flag_c});
      end
      applyStimulus(3'd7, 8'h10, 8'h01, 1'b0, 0, lat, nd, nb, lbm);
      tests++;
      if ({result, flag_z, flag_n, flag_h, flag_c} !== {8'h55, 4'b0110}) begin
         fails++; $display("[TB] FAIL cp_10_01: got %h want 556", {result, flag_z, flag_n, flag_h, flag_c});
      end
      applyStimulus(3'd6, 8'h0F, 8'h30, 1'b0, 0, lat, nd, nb, lbm);
      tests++;
      if ({result, flag_z, flag_n, flag_h, flag_c} !== {8'h3F, 4'b0000}) begin
         fails++; $display("[TB] FAIL or_0f_30: got %h want 3f0", {result, flag_z, flag_n, flag_h, flag_c});
      end
   endtask

   task automatic test_back_to_back();
      int lat, nd, nb; logic [9:0] lbm;
      applyStimulus(3'd4, 8'hF0, 8'h3C, 1'b0, 2, lat, nd, nb, lbm);
      tests++;
      if (nd !== 1) begin fails++; $display("[TB] FAIL busy_start_done_count: got %0d want 1", nd); end
      tests++;
      if (nb !== 4) begin fails++; $display("[TB] FAIL busy_start_busy_cycles: got %0d want 4", nb); end
      tests++;
      if ({result, flag_z, flag_n, flag_h, flag_c} !== {8'h30, 4'b0010}) begin
         fails++; $display("[TB] FAIL busy_start_outcome: got %h want 302", {result, flag_z, flag_n, flag_h, flag_c});
      end
   endtask

   task automatic test_reset_abort();
      int nd;
      @(negedge clk);
      op_sel = 3'd0; opa = 8'h0F; opb = 8'h01; flag_cin = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      tests++;
      if ({busy, done} !== 2'b00) begin
         fails++; $display("[TB] FAIL abort_busy_done: got %b want 00", {busy, done});
      end
      tests++;
      if ({result, flag_z, flag_n, flag_h, flag_c} !== 12'h000) begin
         fails++; $display("[TB] FAIL abort_outcome: got %h want 000", {result, flag_z, flag_n, flag_h, flag_c});
      end
      tests++;
      if (alu_oe !== NO_OE || alu_h !== 1'b0) begin
         fails++; $display("[TB] FAIL abort_alu_idle: got oe=%0d h=%b want 0/0", alu_oe, alu_h);
      end
      @(negedge clk); reset = 1'b0;
      nd = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done) nd++;
      end
      tests++;
      if (nd !== 0) begin fails++; $display("[TB] FAIL abort_no_done: got %0d want 0", nd); end
      tests++;
      if ({busy, result} !== 9'h000) begin
         fails++; $display("[TB] FAIL abort_stays_idle: got %h want 000", {busy, result});
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; op_sel = 3'd0; opa = 8'h00; opb = 8'h00; flag_cin = 1'b0;
      repeat (2) @(posedge clk);
      test_reset();
      test_and();
      test_add();
      test_sub();
      test_cp();
      test_back_to_back();
      test_reset_abort();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
